// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request, buffers one word
// while decode stalls, drops the reply of a flushed request, and owns the IF/ID register.
// Optional misaligned-fetch exception: define FETCH_ADEL_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic        flush,
  input  logic        stallId,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic        pcHold,
  output logic        idValid,
  output logic [31:0] idInstr,
  output logic [31:0] idPc,
  output logic [31:0] idPc4,
  output logic        idExcAdel
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] addr_reg;
  logic [31:0] skid_instr, skid_pc, skid_pc4;
  logic [31:0] fetch_addr, fetch_instr;
  logic        adel, got;
  logic        ld_fetch, ld_skid, ld_bubble, cap_skid;

  assign fetch_addr = {pc[31:2], 2'b00};

`ifdef FETCH_ADEL_CHECK_EN
  assign adel = (pc[1:0] != 2'b00);
`else
  logic unused_pc_bits;
  assign adel           = 1'b0;
  assign unused_pc_bits = ^pc[1:0];
`endif

  // A misaligned fetch completes immediately with a NOP carrying the exception.
  assign got         = adel | imemAck;
  assign fetch_instr = adel ? NOP_INSTR : imemData;

  always_comb begin
    imemReq   = 1'b0;
    imemAddr  = addr_reg;
    pcHold    = 1'b1;
    ld_fetch  = 1'b0;
    ld_skid   = 1'b0;
    ld_bubble = 1'b0;
    cap_skid  = 1'b0;
    state_n   = state;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          imemReq  = !adel;
          imemAddr = fetch_addr;
          if (flush) begin
            ld_bubble = 1'b1;
            pcHold    = 1'b0;
            state_n   = got ? FETCH : DROP;
          end else if (got) begin
            if (!stallId) begin
              ld_fetch = 1'b1;
              pcHold   = 1'b0;
            end else begin
              cap_skid = 1'b1;
              state_n  = HOLD;
            end
          end else if (!stallId) begin
            ld_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (flush) begin
            ld_bubble = 1'b1;
            pcHold    = 1'b0;
            state_n   = FETCH;
          end else if (!stallId) begin
            ld_skid = 1'b1;
            pcHold  = 1'b0;
            state_n = FETCH;
          end
        end
        DROP: begin
          // Keep presenting the flushed request until memory retires it.
          imemReq = 1'b1;
          if (flush) begin
            ld_bubble = 1'b1;
            pcHold    = 1'b0;
          end
          if (imemAck) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // ---- IF/ID register and control state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      addr_reg <= 32'h0;
      idValid  <= 1'b0;
      idInstr  <= NOP_INSTR;
      idPc     <= 32'h0;
      idPc4    <= 32'h0;
    end else begin
      state <= state_n;
      if (state == FETCH) addr_reg <= fetch_addr;
      if (ld_fetch) begin
        idValid <= 1'b1;
        idInstr <= fetch_instr;
        idPc    <= pc;
        idPc4   <= pc4;
      end else if (ld_skid) begin
        idValid <= 1'b1;
        idInstr <= skid_instr;
        idPc    <= skid_pc;
        idPc4   <= skid_pc4;
      end else if (ld_bubble) begin
        idValid <= 1'b0;
        idInstr <= NOP_INSTR;
      end
    end
  end

  // ---- skid buffer (validity is implied by the HOLD state) ----
  always_ff @(posedge clk) begin
    if (cap_skid) begin
      skid_instr <= fetch_instr;
      skid_pc    <= pc;
      skid_pc4   <= pc4;
    end
  end

`ifdef FETCH_ADEL_CHECK_EN
  logic exc_reg, skid_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_reg <= 1'b0;
    end else if (ld_fetch) begin
      exc_reg <= adel;
    end else if (ld_skid) begin
      exc_reg <= skid_exc;
    end else if (ld_bubble) begin
      exc_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cap_skid) skid_exc <= adel;
  end

  assign idExcAdel = exc_reg;
`else
  assign idExcAdel = 1'b0;
`endif

endmodule
